// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for an external 2**abits-entry dual-port RAM.
// Qualifies push/pop, decodes full/empty/almost levels and keeps sticky error flags.
module fifo_ptr_ctrl #(
  parameter int abits  = 4,
  parameter int af_lvl = (1 << abits) - 2,
  parameter int ae_lvl = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic             wen,
  output logic             ren,
  output logic [abits-1:0] waddr,
  output logic [abits-1:0] raddr,
  output logic [abits:0]   count,
  output logic             e,
  output logic             f,
  output logic             ae,
  output logic             af,
  output logic             ovf,
  output logic             udf
);

  localparam logic [abits:0] full_cnt = {1'b1, {abits{1'b0}}};
  localparam logic [abits:0] af_cnt   = af_lvl[abits:0];
  localparam logic [abits:0] ae_cnt   = ae_lvl[abits:0];

  logic [abits-1:0] wptr;
  logic [abits-1:0] rptr;
  logic             flush;

  assign flush = rst | clr;
  assign waddr = wptr;
  assign raddr = rptr;

  assign e  = (count == '0);
  assign f  = (count == full_cnt);
  assign ae = (count <= ae_cnt);
  assign af = (count >= af_cnt);

  // A pop frees a slot in the same cycle, so a push while full is still accepted.
  assign wen = ~flush & inc & (~f | dec);
  assign ren = ~flush & dec & ~e;

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wen) wptr <= wptr + 1'b1;
      if (ren) rptr <= rptr + 1'b1;
      case ({wen, ren})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (inc & ~wen) ovf <= 1'b1;
      if (dec & ~ren) udf <= 1'b1;
    end
  end

endmodule
